// File: rtl/dcache_data_array.sv
// Set-associative D-cache data array: one 8-byte word access per cycle, shared by
// line fills, byte-masked stores and registered reads (fill > store > read).
module dcache_way #(
  parameter int SETS   = 8,
  parameter int WORDS  = 4,
  parameter int SET_W  = 3,
  parameter int WIDX_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [SET_W-1:0]  set,
  input  logic [WIDX_W-1:0] word,
  input  logic [7:0]        be,
  input  logic [63:0]       wdata,
  output logic [63:0]       rword
);
  logic [63:0] mem [SETS][WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 8; b++)
        if (be[b]) mem[set][word][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  assign rword = mem[set][word];
endmodule

module dcache_data_array #(
  parameter int WAYS       = 3,
  parameter int SETS       = 8,
  parameter int LINE_BYTES = 32,
  parameter int BEAT_BYTES = 8,
  parameter int WAY_W      = 2,
  parameter int ADDR_W     = 8,
  localparam int SET_W     = (SETS > 1) ? $clog2(SETS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [WAY_W-1:0]  rd_way,
  output logic              rd_resp_valid,
  output logic [31:0]       rd_data,
  output logic [63:0]       rd_word,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [WAY_W-1:0]  st_way,
  input  logic [1:0]        st_size,
  input  logic [31:0]       st_data,
  input  logic              fill_start,
  output logic              fill_ready,
  input  logic [SET_W-1:0]  fill_set,
  input  logic [WAY_W-1:0]  fill_way,
  input  logic              fill_beat_valid,
  input  logic [63:0]       fill_beat_data,
  output logic              fill_done
);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int WORDS  = LINE_BYTES / BEAT_BYTES;
  localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WIDX_W-1:0] WMASK = WIDX_W'(WORDS - 1);

  typedef enum logic {IDLE, FILL} state_t;

  function automatic logic [SET_W-1:0] set_of(input logic [ADDR_W-1:0] a);
    return SET_W'(a >> OFF_W);
  endfunction

  function automatic logic [WIDX_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return WIDX_W'(a >> 3) & WMASK;
  endfunction

  state_t             state, state_nxt;
  logic [WIDX_W-1:0]  beat_cnt;
  logic [SET_W-1:0]   fill_set_q;
  logic [WAY_W-1:0]   fill_way_q;
  logic               fill_we, fill_last, st_fire, rd_fire, st_hit, rd_hit;
  logic [7:0]         st_base, st_be, wr_be;
  logic [63:0]        st_wdata, wr_data, rd_sel;
  logic [SET_W-1:0]   acc_set;
  logic [WIDX_W-1:0]  acc_word;
  logic [WAYS-1:0][63:0] rwords;

  assign fill_ready = (state == IDLE);
  assign fill_we    = (state == FILL) && fill_beat_valid;
  assign fill_last  = (beat_cnt == WMASK);

  // Accesses to the line under fill wait, so nobody sees or clobbers a half-filled line.
  assign st_hit  = (state == FILL) && set_of(st_addr) == fill_set_q && st_way == fill_way_q;
  assign rd_hit  = (state == FILL) && set_of(rd_addr) == fill_set_q && rd_way == fill_way_q;
  assign st_fire = st_valid && !fill_we && !st_hit;
  assign rd_fire = rd_valid && !fill_we && !st_fire && !rd_hit;
  assign st_ready = st_fire;
  assign rd_ready = rd_fire;

  always_comb begin
    case (st_size)
      2'd0:    st_base = 8'h01;
      2'd1:    st_base = 8'h03;
      2'd2:    st_base = 8'h07;
      default: st_base = 8'h0F;
    endcase
  end

  // Bytes shifted past bit 63 fall off: no wrap into the following word.
  assign st_be    = st_base << st_addr[2:0];
  assign st_wdata = {32'b0, st_data} << {st_addr[2:0], 3'b000};
  assign wr_be    = fill_we ? 8'hFF : st_be;
  assign wr_data  = fill_we ? fill_beat_data : st_wdata;

  always_comb begin
    acc_set  = set_of(rd_addr);
    acc_word = word_of(rd_addr);
    if (fill_we) begin
      acc_set  = fill_set_q;
      acc_word = beat_cnt;
    end else if (st_fire) begin
      acc_set  = set_of(st_addr);
      acc_word = word_of(st_addr);
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic we;
    assign we = (fill_we && fill_way_q == WAY_W'(w)) || (st_fire && st_way == WAY_W'(w));
    dcache_way #(.SETS(SETS), .WORDS(WORDS), .SET_W(SET_W), .WIDX_W(WIDX_W)) u_way (
      .clk(clk), .we(we), .set(acc_set), .word(acc_word),
      .be(wr_be), .wdata(wr_data), .rword(rwords[w])
    );
  end

  always_comb begin
    rd_sel = '0;
    for (int w = 0; w < WAYS; w++)
      if (rd_way == WAY_W'(w)) rd_sel = rwords[w];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_resp_valid <= 1'b0;
      rd_word       <= '0;
      rd_data       <= '0;
    end else begin
      rd_resp_valid <= rd_fire;
      if (rd_fire) begin
        rd_word <= rd_sel;
        rd_data <= 32'(rd_sel >> {rd_addr[2:0], 3'b000});
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fill_start) state_nxt = FILL;
      FILL:    if (fill_we && fill_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      fill_set_q <= '0;
      fill_way_q <= '0;
      fill_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      fill_done <= fill_we && fill_last;
      if (state == IDLE && fill_start) begin
        beat_cnt   <= '0;
        fill_set_q <= fill_set;
        fill_way_q <= fill_way;
      end else if (fill_we) begin
        beat_cnt <= fill_last ? '0 : beat_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dcache_data_array.sv
// Directed bench for dcache_data_array: fills, masked stores, arbitration and mid-fill reset.
module tb_dcache_data_array;
  logic        clk = 1'b0;
  logic        rst;
  logic        rd_valid, rd_ready, rd_resp_valid;
  logic [7:0]  rd_addr;
  logic [1:0]  rd_way;
  logic [31:0] rd_data;
  logic [63:0] rd_word;
  logic        st_valid, st_ready;
  logic [7:0]  st_addr;
  logic [1:0]  st_way, st_size;
  logic [31:0] st_data;
  logic        fill_start, fill_ready, fill_beat_valid, fill_done;
  logic [2:0]  fill_set;
  logic [1:0]  fill_way;
  logic [63:0] fill_beat_data;

  int errors = 0;
  int checks = 0;

  dcache_data_array dut (
    .clk(clk), .rst(rst),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_way(rd_way),
    .rd_resp_valid(rd_resp_valid), .rd_data(rd_data), .rd_word(rd_word),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_way(st_way),
    .st_size(st_size), .st_data(st_data),
    .fill_start(fill_start), .fill_ready(fill_ready), .fill_set(fill_set), .fill_way(fill_way),
    .fill_beat_valid(fill_beat_valid), .fill_beat_data(fill_beat_data), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input string tag, input logic [7:0] a, input logic [1:0] w,
                         output logic [63:0] word, output logic [31:0] data);
    int n = 0;
    rd_valid = 1'b1; rd_addr = a; rd_way = w;
    #1;
    while (!rd_ready && n < 20) begin tick(); n++; end
    chk({tag, "_ready"}, 64'(rd_ready), 64'd1);
    tick();
    rd_valid = 1'b0;
    chk({tag, "_resp_valid"}, 64'(rd_resp_valid), 64'd1);
    word = rd_word;
    data = rd_data;
  endtask

  task automatic do_store(input string tag, input logic [7:0] a, input logic [1:0] w,
                          input logic [1:0] sz, input logic [31:0] d, output int waited);
    waited = 0;
    st_valid = 1'b1; st_addr = a; st_way = w; st_size = sz; st_data = d;
    #1;
    while (!st_ready && waited < 20) begin tick(); waited++; end
    chk({tag, "_ready"}, 64'(st_ready), 64'd1);
    tick();
    st_valid = 1'b0;
  endtask

  logic [63:0] w64;
  logic [31:0] d32;
  int          waited;
  logic [3:0]  nib;

  initial begin
    rst = 1'b1;
    rd_valid = 0; rd_addr = 0; rd_way = 0;
    st_valid = 0; st_addr = 0; st_way = 0; st_size = 0; st_data = 0;
    fill_start = 0; fill_set = 0; fill_way = 0; fill_beat_valid = 0; fill_beat_data = 0;
    #2 rst = 1'b0;
    #1;
    chk("rst_fill_ready", 64'(fill_ready), 64'd1);
    chk("rst_resp_valid", 64'(rd_resp_valid), 64'd0);
    chk("rst_fill_done", 64'(fill_done), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_rd_word", rd_word, 64'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Fill set 2 / way 1 with 0x11.., 0x22.., 0x33.., 0x44..
    fill_start = 1; fill_set = 3'd2; fill_way = 2'd1;
    #1 chk("fill_ready_idle", 64'(fill_ready), 64'd1);
    tick();
    fill_start = 0;
    #1 chk("fill_ready_busy", 64'(fill_ready), 64'd0);
    for (int b = 0; b < 4; b++) begin
      nib = 4'(b + 1);
      fill_beat_valid = 1; fill_beat_data = {16{nib}};
      tick();
      chk($sformatf("fill_done_beat%0d", b), 64'(fill_done), (b == 3) ? 64'd1 : 64'd0);
    end
    fill_beat_valid = 0;
    tick();
    chk("fill_done_pulse_end", 64'(fill_done), 64'd0);
    do_read("rd_58", 8'h58, 2'd1, w64, d32);
    chk("rd_58_word", w64, 64'h4444444444444444);
    chk("rd_58_data", 64'(d32), 64'h44444444);
    tick();
    chk("rd_idle_resp", 64'(rd_resp_valid), 64'd0);
    chk("rd_hold_word", rd_word, 64'h4444444444444444);

    // Store crossing the word end; read back right after
    do_store("st_46", 8'h46, 2'd1, 2'd3, 32'hAABBCCDD, waited);
    do_read("rd_46", 8'h46, 2'd1, w64, d32);
    chk("rd_46_word", w64, 64'hCCDD111111111111);
    chk("rd_46_data", 64'(d32), 64'h0000CCDD);

    // Independent ways
    do_store("st_w0", 8'h40, 2'd0, 2'd3, 32'h12345678, waited);
    do_store("st_w2", 8'h40, 2'd2, 2'd3, 32'h9ABCDEF0, waited);
    do_store("st_w3", 8'h40, 2'd3, 2'd3, 32'hDEADBEEF, waited);
    do_read("rd_w0", 8'h40, 2'd0, w64, d32);
    chk("rd_w0_data", 64'(d32), 64'h12345678);
    do_read("rd_w2", 8'h40, 2'd2, w64, d32);
    chk("rd_w2_data", 64'(d32), 64'h9ABCDEF0);
    do_read("rd_w1", 8'h40, 2'd1, w64, d32);
    chk("rd_w1_word", w64, 64'hCCDD111111111111);

    // Fill set 3 / way 0; beat 0 collides with a store and a read
    fill_start = 1; fill_set = 3'd3; fill_way = 2'd0;
    tick();
    fill_start = 0;
    fill_beat_valid = 1; fill_beat_data = 64'hA0A0A0A0A0A0A0A0;
    st_valid = 1; st_addr = 8'h48; st_way = 2'd1; st_size = 2'd1; st_data = 32'h0000BEEF;
    rd_valid = 1; rd_addr = 8'h50; rd_way = 2'd1;
    #1;
    chk("arb_fill_st_ready", 64'(st_ready), 64'd0);
    chk("arb_fill_rd_ready", 64'(rd_ready), 64'd0);
    tick();
    fill_beat_valid = 0;
    #1;
    chk("arb_st_ready", 64'(st_ready), 64'd1);
    chk("arb_st_rd_ready", 64'(rd_ready), 64'd0);
    chk("arb_no_resp", 64'(rd_resp_valid), 64'd0);
    tick();
    st_valid = 0;
    #1 chk("arb_rd_ready", 64'(rd_ready), 64'd1);
    tick();
    rd_valid = 0;
    chk("arb_rd_resp", 64'(rd_resp_valid), 64'd1);
    chk("arb_rd_word", rd_word, 64'h3333333333333333);

    // Other way in the filling set goes straight through; same way stalls
    do_store("st_60_w1", 8'h60, 2'd1, 2'd3, 32'hCAFEF00D, waited);
    chk("st_60_w1_wait", 64'(waited), 64'd0);
    st_valid = 1; st_addr = 8'h68; st_way = 2'd0; st_size = 2'd0; st_data = 32'h00000055;
    #1 chk("st_hit_stall", 64'(st_ready), 64'd0);
    for (int b = 1; b < 4; b++) begin
      fill_beat_valid = 1;
      fill_beat_data = (b == 1) ? 64'hB1B1B1B1B1B1B1B1 :
                       (b == 2) ? 64'hC2C2C2C2C2C2C2C2 : 64'hD3D3D3D3D3D3D3D3;
      #1 chk($sformatf("st_hit_stall_b%0d", b), 64'(st_ready), 64'd0);
      tick();
    end
    fill_beat_valid = 0;
    #1;
    chk("fill2_done", 64'(fill_done), 64'd1);
    chk("st_hit_release", 64'(st_ready), 64'd1);
    tick();
    st_valid = 0;
    chk("fill2_done_end", 64'(fill_done), 64'd0);
    do_read("rd_68", 8'h68, 2'd0, w64, d32);
    chk("rd_68_word", w64, 64'hB1B1B1B1B1B1B155);
    chk("rd_68_data", 64'(d32), 64'hB1B1B155);
    do_read("rd_60_w1", 8'h60, 2'd1, w64, d32);
    chk("rd_60_w1_data", 64'(d32), 64'hCAFEF00D);
    do_read("rd_48", 8'h48, 2'd1, w64, d32);
    chk("rd_48_word", w64, 64'h222222222222BEEF);
    do_read("rd_78", 8'h78, 2'd0, w64, d32);
    chk("rd_78_word", w64, 64'hD3D3D3D3D3D3D3D3);

    // Mid-fill reset on set 4 / way 2
    do_store("st_90", 8'h90, 2'd2, 2'd3, 32'h01020304, waited);
    do_store("st_98", 8'h98, 2'd2, 2'd3, 32'h05060708, waited);
    do_store("st_9f", 8'h9F, 2'd2, 2'd1, 32'h0000AA55, waited);
    fill_start = 1; fill_set = 3'd4; fill_way = 2'd2;
    tick();
    fill_start = 0;
    fill_beat_valid = 1; fill_beat_data = 64'hE0E0E0E0E0E0E0E0;
    tick();
    fill_beat_data = 64'hE1E1E1E1E1E1E1E1;
    tick();
    fill_beat_valid = 0;
    rst = 1'b0;
    #1;
    chk("mid_rst_fill_ready", 64'(fill_ready), 64'd1);
    chk("mid_rst_fill_done", 64'(fill_done), 64'd0);
    chk("mid_rst_rd_word", rd_word, 64'd0);
    tick();
    rst = 1'b1;
    fill_beat_valid = 1; fill_beat_data = 64'hFFFFFFFFFFFFFFFF;
    tick();
    fill_beat_valid = 0;
    chk("idle_beat_no_done", 64'(fill_done), 64'd0);
    tick();
    chk("idle_beat_no_done2", 64'(fill_done), 64'd0);
    do_read("rd_80", 8'h80, 2'd2, w64, d32);
    chk("rd_80_word", w64, 64'hE0E0E0E0E0E0E0E0);
    do_read("rd_88", 8'h88, 2'd2, w64, d32);
    chk("rd_88_word", w64, 64'hE1E1E1E1E1E1E1E1);
    do_read("rd_90", 8'h90, 2'd2, w64, d32);
    chk("rd_90_data", 64'(d32), 64'h01020304);
    do_read("rd_98", 8'h98, 2'd2, w64, d32);
    chk("rd_98_data", 64'(d32), 64'h05060708);
    do_read("rd_9f", 8'h9F, 2'd2, w64, d32);
    chk("rd_9f_data", 64'(d32), 64'h00000055);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
